// File: rtl/alu_iter_sequencer.sv
// ============================================================================
// Module   : alu_iter_sequencer
// Brief    : Feeds an external 8-bit constant ALU its own result for N passes,
//            then returns the final value over a valid/ready handshake.
//            Optional early stop on zero: define STOP_ON_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter_sequencer #(
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_seed,
    input  logic [1:0]        cmd_const_sel,
    input  logic [1:0]        cmd_op,
    input  logic [ITER_W-1:0] cmd_iter,
    output logic [7:0]        alu_input,
    output logic [1:0]        alu_const_sel,
    output logic [1:0]        alu_op,
    input  logic [7:0]        alu_output,
    input  logic              alu_status,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic              res_zero,
    output logic              res_early
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ITER_W-1:0] c_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        op_q, op_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [7:0]        res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
`ifdef STOP_ON_ZERO_EN
    logic              res_early_q, res_early_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 8'd0;
            sel_q       <= 2'd0;
            op_q        <= 2'd0;
            cnt_q       <= '0;
            res_data_q  <= 8'd0;
            res_zero_q  <= 1'b0;
`ifdef STOP_ON_ZERO_EN
            res_early_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sel_q       <= sel_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
`ifdef STOP_ON_ZERO_EN
            res_early_q <= res_early_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sel_d       = sel_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
`ifdef STOP_ON_ZERO_EN
        res_early_d = res_early_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    acc_d      = cmd_seed;
                    sel_d      = cmd_const_sel;
                    op_d       = cmd_op;
                    cnt_d      = cmd_iter;
                    // Zero-pass commands already hold their answer here; RUN just
                    // spends one cycle so every command has at least one cycle of latency.
                    res_data_d = cmd_seed;
                    res_zero_d = (cmd_seed == 8'd0);
`ifdef STOP_ON_ZERO_EN
                    res_early_d = 1'b0;
`endif
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    acc_d = alu_output;
                    cnt_d = cnt_q - c_ONE;
                    if (cnt_q == c_ONE) begin
                        res_data_d = alu_output;
                        res_zero_d = alu_status;
                        state_d    = S_HOLD;
                    end
`ifdef STOP_ON_ZERO_EN
                    else if (alu_status) begin
                        res_data_d  = 8'd0;
                        res_zero_d  = 1'b1;
                        res_early_d = 1'b1;
                        state_d     = S_HOLD;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign res_valid     = (state_q == S_HOLD);
    assign alu_input     = acc_q;
    assign alu_const_sel = sel_q;
    assign alu_op        = op_q;
    assign res_data      = res_data_q;
    assign res_zero      = res_zero_q;
`ifdef STOP_ON_ZERO_EN
    assign res_early     = res_early_q;
`else
    assign res_early     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_iter_sequencer.sv
// ============================================================================
// Module   : tb_alu_iter_sequencer
// Brief    : Directed bench for alu_iter_sequencer with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_iter_sequencer;

    localparam int ITER_W = 4;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_seed;
    logic [1:0]        cmd_const_sel;
    logic [1:0]        cmd_op;
    logic [ITER_W-1:0] cmd_iter;
    logic [7:0]        alu_input;
    logic [1:0]        alu_const_sel;
    logic [1:0]        alu_op;
    logic [7:0]        alu_output;
    logic              alu_status;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_data;
    logic              res_zero;
    logic              res_early;

    int n_cmp;
    int n_err;

    alu_iter_sequencer #(.ITER_W(ITER_W)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_seed      (cmd_seed),
        .cmd_const_sel (cmd_const_sel),
        .cmd_op        (cmd_op),
        .cmd_iter      (cmd_iter),
        .alu_input     (alu_input),
        .alu_const_sel (alu_const_sel),
        .alu_op        (alu_op),
        .alu_output    (alu_output),
        .alu_status    (alu_status),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_zero      (res_zero),
        .res_early     (res_early)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural constant ALU
    logic [7:0] w_k;
    always_comb begin
        w_k = 8'd1;
        case (alu_const_sel)
            2'd0: w_k = 8'd1;
            2'd1: w_k = 8'd3;
            2'd2: w_k = 8'd5;
            2'd3: w_k = 8'd7;
            default: w_k = 8'd1;
        endcase
        alu_output = alu_input + w_k;
        case (alu_op)
            2'd0: alu_output = alu_input + w_k;
            2'd1: alu_output = alu_input - w_k;
            2'd2: alu_output = alu_input & w_k;
            2'd3: alu_output = alu_input | w_k;
            default: alu_output = alu_input;
        endcase
        alu_status = (alu_output == 8'd0);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command; returns edges from accept to res_valid
    task automatic issue(input logic [7:0] seed, input logic [1:0] sel, input logic [1:0] op,
                         input logic [ITER_W-1:0] iter, output int lat);
        check_val("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_seed = seed; cmd_const_sel = sel; cmd_op = op; cmd_iter = iter;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("res_valid_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic take_result;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_val("res_valid_after_hs", {31'd0, res_valid}, 32'd0);
        check_val("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [7:0] seed, input logic [1:0] sel,
                             input logic [1:0] op, input logic [ITER_W-1:0] iter,
                             input int exp_lat, input logic [7:0] exp_data,
                             input logic exp_zero, input logic exp_early);
        int lat;
        issue(seed, sel, op, iter, lat);
        check_val({tag, "_lat"},   lat, exp_lat);
        check_val({tag, "_data"},  {24'd0, res_data}, {24'd0, exp_data});
        check_val({tag, "_zero"},  {31'd0, res_zero}, {31'd0, exp_zero});
        check_val({tag, "_early"}, {31'd0, res_early}, {31'd0, exp_early});
        take_result();
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_seed = 8'd0; cmd_const_sel = 2'd0; cmd_op = 2'd0; cmd_iter = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("rst_res_data",  {24'd0, res_data}, 32'd0);
        check_val("rst_res_zero",  {31'd0, res_zero}, 32'd0);
        check_val("rst_res_early", {31'd0, res_early}, 32'd0);
        check_val("rst_alu_input", {24'd0, alu_input}, 32'd0);
        check_val("rst_alu_ctl",   {28'd0, alu_const_sel, alu_op}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 10 + 3 four times = 22
        run_check("t1", 8'd10, 2'd1, 2'd0, 4'd4, 4, 8'd22, 1'b0, 1'b0);

        // 2: 0xFE + 1 three times wraps through 0x00 on pass 2
`ifdef STOP_ON_ZERO_EN
        run_check("t2", 8'hFE, 2'd0, 2'd0, 4'd3, 2, 8'h00, 1'b1, 1'b1);
`else
        run_check("t2", 8'hFE, 2'd0, 2'd0, 4'd3, 3, 8'h01, 1'b0, 1'b0);
`endif

        // 3: 0xFF & 7 twice = 7; consumer stalls, stray command pulse ignored
        issue(8'hFF, 2'd3, 2'd2, 4'd2, lat);
        check_val("t3_lat", lat, 2);
        check_val("t3_alu_ctl", {28'd0, alu_const_sel, alu_op}, {28'd0, 2'd3, 2'd2});
        cmd_seed = 8'h99; cmd_iter = 4'd1;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 2);
            @(posedge clk); #1;
            check_val("t3_hold_valid", {31'd0, res_valid}, 32'd1);
            check_val("t3_hold_data",  {24'd0, res_data}, 32'h07);
            check_val("t3_hold_zero",  {31'd0, res_zero}, 32'd0);
            check_val("t3_hold_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        take_result();
        repeat (2) @(posedge clk);
        #1;
        check_val("t3_no_accept", {31'd0, res_valid}, 32'd0);
        check_val("t3_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // 4: zero passes returns seed one cycle after accept
        cmd_seed = 8'h55; cmd_const_sel = 2'd0; cmd_op = 2'd0; cmd_iter = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_val("t4_busy", {31'd0, cmd_ready}, 32'd0);
        check_val("t4_not_yet", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        check_val("t4_valid", {31'd0, res_valid}, 32'd1);
        check_val("t4_data", {24'd0, res_data}, 32'h55);
        check_val("t4_zero", {31'd0, res_zero}, 32'd0);
        check_val("t4_busy_hold", {31'd0, cmd_ready}, 32'd0);
        take_result();

        // 5: 15 - 5 hits zero on pass 3 of 5
`ifdef STOP_ON_ZERO_EN
        run_check("t5", 8'd15, 2'd2, 2'd1, 4'd5, 3, 8'h00, 1'b1, 1'b1);
`else
        run_check("t5", 8'd15, 2'd2, 2'd1, 4'd5, 5, 8'hF6, 1'b0, 1'b0);
`endif

        // 6: asynchronous reset in the middle of an 8-pass run
        cmd_seed = 8'd1; cmd_const_sel = 2'd1; cmd_op = 2'd0; cmd_iter = 4'd8;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("t6_mid_acc", {24'd0, alu_input}, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_valid", {31'd0, res_valid}, 32'd0);
        check_val("t6_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("t6_rst_acc",   {24'd0, alu_input}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_check("t6_after", 8'd10, 2'd1, 2'd0, 4'd4, 4, 8'd22, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
